// File: rtl/vj_scan_pkg.sv
// Pyramid geometry and scheduler state encoding shared by the Viola-Jones scan scheduler.
package vj_scan_pkg;

    localparam int unsigned PYRAMID_LEVELS = 9;
    localparam int unsigned WINDOW_SIZE    = 24;
    localparam logic [3:0]  IMG_INDEX_IDLE = 4'd15;

    // Level 0 is the full-resolution image; each level shrinks by roughly 1.25x.
    localparam int unsigned PYRAMID_WIDTHS [PYRAMID_LEVELS] =
        '{320, 256, 205, 164, 131, 105, 84, 67, 54};
    localparam int unsigned PYRAMID_HEIGHTS [PYRAMID_LEVELS] =
        '{240, 192, 154, 123, 98, 79, 63, 50, 40};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_INT = 2'd1,
        ST_SCAN     = 2'd2,
        ST_DONE     = 2'd3
    } scan_state_e;

endpackage

// File: rtl/scan_level_limits.sv
// Maps a pyramid level to the last legal window column/row; idle or
// out-of-range indices (including 15) yield zero limits.
module scan_level_limits
    import vj_scan_pkg::*;
(
    input  logic [3:0]  img_index,
    output logic [31:0] colmax,
    output logic [31:0] rowmax
);

    // Table lookup of the level geometry, reduced to the last window origin.
    always_comb begin
        colmax = 32'd0;
        rowmax = 32'd0;
        for (int unsigned lvl = 0; lvl < PYRAMID_LEVELS; lvl++) begin
            if (img_index == 4'(lvl)) begin
                colmax = 32'(PYRAMID_WIDTHS[lvl]) - 32'(WINDOW_SIZE) - 32'd1;
                rowmax = 32'(PYRAMID_HEIGHTS[lvl]) - 32'(WINDOW_SIZE) - 32'd1;
            end
        end
    end

endmodule

// File: rtl/scan_scheduler.sv
// Scan scheduler: waits for the integral image to settle after img_rdy, then walks
// detection windows in raster order over pyramid levels START_LEVEL..last.
// Optional feature: define SCAN_WIN_COUNT_EN to add the win_count accepted-window counter.
module scan_scheduler
    import vj_scan_pkg::*;
#(
    parameter int unsigned START_LEVEL  = 7,
    parameter int unsigned INT_IMG_WAIT = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        img_rdy,
    input  logic        abort,
    input  logic        win_accept,
    output logic [3:0]  img_index,
    output logic [31:0] row_index,
    output logic [31:0] col_index,
    output logic        win_valid,
    output logic        level_start,
    output logic        busy,
    output logic        done
`ifdef SCAN_WIN_COUNT_EN
    ,
    output logic [31:0] win_count
`endif
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned POS_W = 32;
    localparam logic [IDX_W-1:0] LAST_LEVEL  = IDX_W'(PYRAMID_LEVELS - 1);
    localparam logic [IDX_W-1:0] FIRST_LEVEL = IDX_W'(START_LEVEL);
    localparam logic [POS_W-1:0] WAIT_LAST   = POS_W'(INT_IMG_WAIT);

    if (START_LEVEL >= PYRAMID_LEVELS) begin : g_bad_start_level
        $error("scan_scheduler: START_LEVEL must be below PYRAMID_LEVELS");
    end

    scan_state_e       state_q, state_d;
    logic [IDX_W-1:0]  img_index_q, img_index_d;
    logic [POS_W-1:0]  row_index_q, row_index_d;
    logic [POS_W-1:0]  col_index_q, col_index_d;
    logic [POS_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              win_valid_q, win_valid_d;
    logic              level_start_q, level_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [POS_W-1:0]  colmax, rowmax;
`ifdef SCAN_WIN_COUNT_EN
    logic [POS_W-1:0]  win_count_q, win_count_d;
`endif

    scan_level_limits u_limits (
        .img_index (img_index_q),
        .colmax    (colmax),
        .rowmax    (rowmax)
    );

    // Next-state, index stepping and registered-output decode.
    always_comb begin
        state_d       = state_q;
        img_index_d   = img_index_q;
        row_index_d   = row_index_q;
        col_index_d   = col_index_q;
        wait_cnt_d    = wait_cnt_q;
        level_start_d = 1'b0;
`ifdef SCAN_WIN_COUNT_EN
        win_count_d   = win_count_q;
`endif

        if (abort) begin
            state_d     = ST_IDLE;
            img_index_d = IMG_INDEX_IDLE;
            row_index_d = '0;
            col_index_d = '0;
            wait_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (img_rdy) begin
                        state_d    = ST_WAIT_INT;
                        wait_cnt_d = POS_W'(1);
`ifdef SCAN_WIN_COUNT_EN
                        win_count_d = '0;
`endif
                    end
                end
                ST_WAIT_INT: begin
                    // A fresh image restarts settling even on the final wait cycle.
                    if (img_rdy) begin
                        wait_cnt_d = POS_W'(1);
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d       = ST_SCAN;
                        img_index_d   = FIRST_LEVEL;
                        row_index_d   = '0;
                        col_index_d   = '0;
                        wait_cnt_d    = '0;
                        level_start_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + POS_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (win_accept) begin
`ifdef SCAN_WIN_COUNT_EN
                        win_count_d = win_count_q + POS_W'(1);
`endif
                        if (col_index_q != colmax) begin
                            col_index_d = col_index_q + POS_W'(1);
                        end else if (row_index_q != rowmax) begin
                            col_index_d = '0;
                            row_index_d = row_index_q + POS_W'(1);
                        end else if (img_index_q != LAST_LEVEL) begin
                            img_index_d   = img_index_q + IDX_W'(1);
                            row_index_d   = '0;
                            col_index_d   = '0;
                            level_start_d = 1'b1;
                        end else begin
                            state_d     = ST_DONE;
                            img_index_d = IMG_INDEX_IDLE;
                            row_index_d = '0;
                            col_index_d = '0;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d     = ST_IDLE;
                    img_index_d = IMG_INDEX_IDLE;
                    row_index_d = '0;
                    col_index_d = '0;
                    wait_cnt_d  = '0;
                end
            endcase
        end

        win_valid_d = (state_d == ST_SCAN);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            img_index_q   <= IMG_INDEX_IDLE;
            row_index_q   <= '0;
            col_index_q   <= '0;
            wait_cnt_q    <= '0;
            win_valid_q   <= 1'b0;
            level_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef SCAN_WIN_COUNT_EN
            win_count_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            img_index_q   <= img_index_d;
            row_index_q   <= row_index_d;
            col_index_q   <= col_index_d;
            wait_cnt_q    <= wait_cnt_d;
            win_valid_q   <= win_valid_d;
            level_start_q <= level_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef SCAN_WIN_COUNT_EN
            win_count_q   <= win_count_d;
`endif
        end
    end

    assign img_index   = img_index_q;
    assign row_index   = row_index_q;
    assign col_index   = col_index_q;
    assign win_valid   = win_valid_q;
    assign level_start = level_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
`ifdef SCAN_WIN_COUNT_EN
    assign win_count   = win_count_q;
`endif

endmodule

// File: tb/tb_scan_scheduler.sv
// Scoreboard bench for scan_scheduler: the scan model pushes every expected window
// when a scan is launched; a negedge monitor pops and checks each presented window.
// Builds with or without SCAN_WIN_COUNT_EN.
`timescale 1ns/1ps
module tb_scan_scheduler;

    localparam int unsigned START_LEVEL  = 7;
    localparam int unsigned INT_IMG_WAIT = 10;
    localparam int unsigned N_LEVELS     = 9;
    localparam int unsigned WIN          = 24;
    localparam int unsigned IDLE_IDX     = 15;
    localparam int unsigned BUDGET       = 20000;

    logic        clock;
    logic        reset;
    logic        img_rdy;
    logic        abort;
    logic        win_accept;
    logic [3:0]  img_index;
    logic [31:0] row_index;
    logic [31:0] col_index;
    logic        win_valid;
    logic        level_start;
    logic        busy;
    logic        done;
`ifdef SCAN_WIN_COUNT_EN
    logic [31:0] win_count;
`endif

    typedef struct {
        int unsigned lvl;
        int unsigned row;
        int unsigned col;
        bit          ls;
    } win_t;

    win_t        exp_q[$];
    win_t        mon_last;
    int unsigned lvl_w [N_LEVELS];
    int unsigned lvl_h [N_LEVELS];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned done_cnt    = 0;
    bit          prev_valid  = 1'b0;
    bit          prev_acc    = 1'b0;

    scan_scheduler #(
        .START_LEVEL  (START_LEVEL),
        .INT_IMG_WAIT (INT_IMG_WAIT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .img_rdy     (img_rdy),
        .abort       (abort),
        .win_accept  (win_accept),
        .img_index   (img_index),
        .row_index   (row_index),
        .col_index   (col_index),
        .win_valid   (win_valid),
        .level_start (level_start),
        .busy        (busy),
        .done        (done)
`ifdef SCAN_WIN_COUNT_EN
        ,
        .win_count   (win_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: a window is "new" after an idle cycle or an accepted one; otherwise it must hold.
    always @(negedge clock) begin
        if (done) done_cnt++;
        if (win_valid) begin
            if (!prev_valid || prev_acc) begin
                check("expected_window_available", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_last = exp_q.pop_front();
                    check("win_img_index", 64'(img_index), 64'(mon_last.lvl));
                    check("win_row", 64'(row_index), 64'(mon_last.row));
                    check("win_col", 64'(col_index), 64'(mon_last.col));
                    check("win_level_start", 64'(level_start), 64'(mon_last.ls));
                end
            end else begin
                check("hold_img_index", 64'(img_index), 64'(mon_last.lvl));
                check("hold_row", 64'(row_index), 64'(mon_last.row));
                check("hold_col", 64'(col_index), 64'(mon_last.col));
                check("hold_level_start", 64'(level_start), 64'd0);
            end
        end else begin
            check("no_window_level_start", 64'(level_start), 64'd0);
        end
        prev_valid = win_valid;
        prev_acc   = win_valid && win_accept && !abort && !reset;
    end

    // Reference scan: every window origin of every scanned level, raster order.
    task automatic push_scan(output int unsigned total);
        total = 0;
        for (int unsigned l = START_LEVEL; l < N_LEVELS; l++) begin
            for (int unsigned r = 0; r + WIN < lvl_h[l]; r++) begin
                for (int unsigned c = 0; c + WIN < lvl_w[l]; c++) begin
                    exp_q.push_back('{l, r, c, (r == 0 && c == 0)});
                    total++;
                end
            end
        end
    endtask

    task automatic pulse_rdy();
        img_rdy = 1'b1;
        @(posedge clock); #1;
        img_rdy = 1'b0;
    endtask

    // After the edge that samples img_rdy, the first window appears INT_IMG_WAIT edges later.
    task automatic wait_first_window();
        int unsigned n = 0;
        while (!win_valid && n < 4 * INT_IMG_WAIT + 8) begin
            win_accept = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            n++;
        end
        check("first_window_latency", 64'(n), 64'(INT_IMG_WAIT));
    endtask

    task automatic start_scan(output int unsigned total);
        push_scan(total);
        pulse_rdy();
        check("busy_after_img_rdy", 64'(busy), 64'd1);
        check("no_window_in_wait", 64'(win_valid), 64'd0);
        check("img_index_in_wait", 64'(img_index), 64'(IDLE_IDX));
`ifdef SCAN_WIN_COUNT_EN
        check("win_count_cleared", 64'(win_count), 64'd0);
`endif
        wait_first_window();
    endtask

    // mode 0: accept always, 1: random accept, 2: alternate accept.
    task automatic run_to_done(input int unsigned mode, input int unsigned total);
        int unsigned n  = 0;
        int unsigned d0 = done_cnt;
        while (!done && n < BUDGET) begin
            case (mode)
                0:       win_accept = 1'b1;
                1:       win_accept = 1'($urandom_range(0, 1));
                default: win_accept = ~win_accept;
            endcase
            img_rdy = ($urandom_range(0, 7) == 0);
            @(posedge clock); #1;
            n++;
        end
        check("scan_finished_in_budget", 64'(done), 64'd1);
        check("all_windows_seen", 64'(exp_q.size()), 64'd0);
        check("done_img_index", 64'(img_index), 64'(IDLE_IDX));
        check("done_row", 64'(row_index), 64'd0);
        check("done_col", 64'(col_index), 64'd0);
        check("done_no_window", 64'(win_valid), 64'd0);
        check("done_busy", 64'(busy), 64'd1);
`ifdef SCAN_WIN_COUNT_EN
        check("win_count_total", 64'(win_count), 64'(total));
`endif
        img_rdy    = 1'b1;
        win_accept = 1'b1;
        @(posedge clock); #1;
        img_rdy    = 1'b0;
        win_accept = 1'b0;
        check("done_single_cycle", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        check("idle_img_index", 64'(img_index), 64'(IDLE_IDX));
        check("done_pulse_count", 64'(done_cnt - d0), 64'd1);
        repeat (2) @(posedge clock);
        #1;
        check("img_rdy_in_done_ignored", 64'(busy), 64'd0);
`ifdef SCAN_WIN_COUNT_EN
        check("win_count_holds", 64'(win_count), 64'(total));
`endif
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_img_index"}, 64'(img_index), 64'(IDLE_IDX));
        check({tag, "_row"}, 64'(row_index), 64'd0);
        check({tag, "_col"}, 64'(col_index), 64'd0);
        check({tag, "_win_valid"}, 64'(win_valid), 64'd0);
        check({tag, "_level_start"}, 64'(level_start), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int unsigned total;
        int unsigned n;
        int unsigned d0;

        lvl_w = '{320, 256, 205, 164, 131, 105, 84, 67, 54};
        lvl_h = '{240, 192, 154, 123, 98, 79, 63, 50, 40};
        reset      = 1'b0;
        img_rdy    = 1'b0;
        abort      = 1'b0;
        win_accept = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_idle("reset");
`ifdef SCAN_WIN_COUNT_EN
        check("reset_win_count", 64'(win_count), 64'd0);
`endif
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock); #1;

        // Full scans under three accept patterns.
        start_scan(total);
        run_to_done(0, total);
        start_scan(total);
        run_to_done(1, total);
        start_scan(total);
        run_to_done(2, total);

        // Abort at row 3, col 5 while img_rdy and win_accept are also high.
        start_scan(total);
        n = 0;
        while (!(win_valid && row_index == 32'd3 && col_index == 32'd5) && n < BUDGET) begin
            win_accept = 1'b1;
            @(posedge clock); #1;
            n++;
        end
        check("reached_row3_col5", 64'(win_valid && row_index == 32'd3 && col_index == 32'd5), 64'd1);
        d0         = done_cnt;
        abort      = 1'b1;
        win_accept = 1'b1;
        img_rdy    = 1'b1;
        @(posedge clock); #1;
        abort      = 1'b0;
        win_accept = 1'b0;
        img_rdy    = 1'b0;
        exp_q.delete();
        check_idle("abort");
        repeat (3) @(posedge clock);
        #1;
        check("abort_stays_idle", 64'(busy), 64'd0);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        start_scan(total);
        run_to_done(1, total);

        // img_rdy re-pulsed while the wait counter reads 6 restarts settling.
        push_scan(total);
        pulse_rdy();
        win_accept = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            check("no_window_before_restart", 64'(win_valid), 64'd0);
        end
        pulse_rdy();
        check("busy_after_restart", 64'(busy), 64'd1);
        wait_first_window();
        run_to_done(1, total);

        // Asynchronous reset in the middle of a scan.
        start_scan(total);
        repeat (40) begin
            win_accept = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        #3 reset = 1'b1;
        #1;
        exp_q.delete();
        check_idle("async_reset");
`ifdef SCAN_WIN_COUNT_EN
        check("async_reset_win_count", 64'(win_count), 64'd0);
`endif
        @(posedge clock);
        #2 reset = 1'b0;
        win_accept = 1'b0;
        @(posedge clock); #1;
        check("post_reset_idle", 64'(busy), 64'd0);
        start_scan(total);
        run_to_done(1, total);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
